multicycle_datapath: RTL and testbench
======================================

# multicycle_datapath

Datapath for the multicycle MIPS-subset core. It holds the PC, IR, MDR, A/B, ALUOut and the 32×32 register file. It executes the per-cycle control word issued by the core's control FSM and returns the current opcode to it. It sits between the control unit and the unified instruction/data memory.

## Interface
Parameters:
- DATA_W, 32, datapath and address width; fixed at 32, present for package consistency.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- ALUOp  in  1  0 = decode IR funct field, 1 = force ADD.
- PCWriteCond  in  1  PC load enable, qualified by ALU zero.
- ALUSrcB  in  2  00 = B, 01 = const 4, 10 = sext(imm16), 11 = sext(imm16)<<2.
- PCSource  in  2  00 = ALU result (combinational), 01 = ALUOut, 10 = {PC[31:28], IR[25:0], 2'b00}, 11 = hold.
- PCWrite, IorD, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  in  1 each  standard multicycle controls.
- opCode  out  6  IR[31:26].
- mem_addr  out  32  IorD ? ALUOut : PC.
- mem_wdata  out  32  B register.
- mem_we  out  1  MemWrite & ~reset.
- mem_rdata  in  32  memory read data, combinational from mem_addr.

## Operation
- Reset state: PC = RESET_PC; IR, MDR, A, B, ALUOut and all registers = 0. Outputs after reset: opCode 0, mem_addr RESET_PC, mem_wdata 0, mem_we 0.
- IR loads mem_rdata only on IRWrite. MDR, A (rs), B (rt) and ALUOut load unconditionally every cycle.
- ALU input A is ALUSrcA ? A : PC. ALU input B is selected per ALUSrcB.
- ALU functions with ALUOp = 0, by funct:
  - 100000 add, 100010 sub, 100100 and, 100101 or.
  - 101010 slt: signed compare, result 1 or 0.
  - Any other funct: result 0.
- Arithmetic is modulo 2^32. There is no overflow detection or trap. zero = (result == 0).
- PC loads the PCSource-selected value when PCWrite | (PCWriteCond & zero). PCWrite dominates when both enables are high. PCSource = 11 leaves PC unchanged even when enabled.
- Register write on RegWrite:
  - Destination: RegDst ? IR[15:11] : IR[20:16].
  - Data: MemtoReg ? MDR : ALUOut.
  - Writes to $0 are discarded, and $0 always reads 0.
- Register file reads are combinational. A write and an A/B latch on the same edge latch the old value (no bypass).
- Reset overrides every control input during the reset cycle: no register, memory or PC update.

## Timing
- All state changes on posedge clk. There are no handshakes; the control FSM owns sequencing.
- opCode is valid the cycle after IRWrite.
- A/B reflect IR one cycle after the IR load.
- ALUOut holds the previous cycle's ALU result (1-cycle latency).
- mem_addr, mem_we and mem_wdata are combinational from registered state and control.
- Reset deasserted mid-instruction: datapath restarts from RESET_PC with cleared state. In-flight writes in that cycle are lost.

## Configuration
- DATAPATH_DBG_PORT_EN defined:
  - Adds input dbg_sel[4:0], plus outputs dbg_reg[31:0] (combinational read of register dbg_sel) and dbg_pc[31:0].
  - The debug read port does not affect functional reads.
- Undefined: those ports and their read logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package datapath_pkg holds:
  - funct constants (ADD/SUB/AND/OR/SLT);
  - ALUSrcB and PCSource encodings;
  - opcode width (6), register-index width (5), DATA_W.
- One sub-module, register_file: 32×32, two combinational read ports, one synchronous write port, $0 hardwired, synchronous reset clears all entries.
- ALU and muxes stay inline.

## Test plan
- Reset: hold reset 1 cycle with PCWrite = 1 and IRWrite = 1 → PC = 0, opCode = 0, mem_we = 0, no IR load.
- ADDI:
  - Fetch mem_rdata = 0x20080005 with IRWrite → opCode = 6'b001000.
  - Then ALUSrcA = 1, ALUSrcB = 10, ALUOp = 1 → ALUOut = 5.
  - Then RegWrite, RegDst = 0 → $8 = 5.
- R-type with $8 = 5, $9 = 7:
  - IR = 0x01095022 (sub $10) → $10 = 0xFFFFFFFE.
  - IR = 0x0109502A (slt) → $10 = 1.
  - Write to $0 → $0 still reads 0.
- PC increment: ALUSrcA = 0, ALUSrcB = 01, ALUOp = 1, PCSource = 00, PCWrite → PC 0→4; from 0xFFFFFFFC → 0 (wrap).
- Jump: PC = 0x40000004, IR = 0x08000010, PCSource = 10, PCWrite → PC = 0x40000040.
- Branch: ALUOut = 0x100, PCSource = 01, PCWriteCond = 1:
  - A = B = 3, ALUSrcA = 1, ALUSrcB = 00, ALUOp = 1, funct = 100010 → PC = 0x100.
  - With A ≠ B → PC unchanged.

Source files
------------

// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : datapath_pkg
//  Purpose  : Shared constants for the multicycle MIPS-subset datapath:
//             widths, ALU funct codes, ALUSrcB and PCSource encodings and a
//             small immediate sign-extension helper.
//  Revision : 1.0  initial release
// ============================================================================
package datapath_pkg;

    localparam int c_DATA_W    = 32;
    localparam int c_OPCODE_W  = 6;
    localparam int c_REG_IDX_W = 5;

    // R-type funct field values understood by the ALU
    localparam logic [5:0] c_FUNCT_ADD = 6'b100000;
    localparam logic [5:0] c_FUNCT_SUB = 6'b100010;
    localparam logic [5:0] c_FUNCT_AND = 6'b100100;
    localparam logic [5:0] c_FUNCT_OR  = 6'b100101;
    localparam logic [5:0] c_FUNCT_SLT = 6'b101010;

    // ALU operand B select
    localparam logic [1:0] c_SRCB_REG     = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR    = 2'b01;
    localparam logic [1:0] c_SRCB_IMM     = 2'b10;
    localparam logic [1:0] c_SRCB_IMM_SH2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] c_PCSRC_HOLD   = 2'b11;

    function automatic logic [c_DATA_W-1:0] sign_extend16(input logic [15:0] imm);
        return {{(c_DATA_W-16){imm[15]}}, imm};
    endfunction

endpackage
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
//  Module   : register_file
//  Purpose  : 32 x DATA_W register file. Two combinational read ports, one
//             synchronous write port, entry 0 hardwired to zero, synchronous
//             reset clears every entry.
//  Ports    : clk, rst            clock / synchronous active-high reset
//             i_rd_addr_a/b       read addresses, o_rd_data_a/b read data
//             i_wr_en/addr/data   write port (writes to entry 0 dropped)
//             i_dbg_addr/o_dbg_data  extra read port, only when
//                                 DATAPATH_DBG_PORT_EN is defined
//  Revision : 1.0  initial release
// ============================================================================
module register_file
    import datapath_pkg::*;
#(
    parameter int DATA_W = c_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [c_REG_IDX_W-1:0] i_rd_addr_a,
    input  logic [c_REG_IDX_W-1:0] i_rd_addr_b,
    output logic [DATA_W-1:0]      o_rd_data_a,
    output logic [DATA_W-1:0]      o_rd_data_b,
`ifdef DATAPATH_DBG_PORT_EN
    input  logic [c_REG_IDX_W-1:0] i_dbg_addr,
    output logic [DATA_W-1:0]      o_dbg_data,
`endif
    input  logic                   i_wr_en,
    input  logic [c_REG_IDX_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]      i_wr_data
);

    localparam int c_NUM_REGS = 1 << c_REG_IDX_W;

    logic [DATA_W-1:0] r_regs [c_NUM_REGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_regs[i_wr_addr] <= i_wr_data;
        end
    end

    // Entry 0 is never written, but the explicit mux keeps $0 at zero
    // regardless of how the storage array is mapped.
    assign o_rd_data_a = (i_rd_addr_a == '0) ? '0 : r_regs[i_rd_addr_a];
    assign o_rd_data_b = (i_rd_addr_b == '0) ? '0 : r_regs[i_rd_addr_b];

`ifdef DATAPATH_DBG_PORT_EN
    assign o_dbg_data  = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
`endif

endmodule
`default_nettype wire

// File: rtl/multicycle_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_datapath
//  Purpose  : Datapath of the multicycle MIPS-subset core. Holds PC, IR, MDR,
//             A, B, ALUOut and the register file, executes the per-cycle
//             control word from the control FSM and returns the opcode.
//  Ports    : clk, reset         clock / synchronous active-high reset
//             control inputs     ALUOp, PCWriteCond, ALUSrcB, PCSource,
//                                PCWrite, IorD, MemWrite, MemtoReg, IRWrite,
//                                ALUSrcA, RegWrite, RegDst
//             opCode             IR[31:26] back to the control FSM
//             mem_addr/wdata/we  unified memory request (combinational)
//             mem_rdata          memory read data
//             dbg_sel/dbg_reg/dbg_pc  debug view, only with
//                                DATAPATH_DBG_PORT_EN defined
//  Revision : 1.0  initial release
// ============================================================================
module multicycle_datapath
    import datapath_pkg::*;
#(
    parameter int                DATA_W   = c_DATA_W,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ALUOp,
    input  logic                  PCWriteCond,
    input  logic [1:0]            ALUSrcB,
    input  logic [1:0]            PCSource,
    input  logic                  PCWrite,
    input  logic                  IorD,
    input  logic                  MemWrite,
    input  logic                  MemtoReg,
    input  logic                  IRWrite,
    input  logic                  ALUSrcA,
    input  logic                  RegWrite,
    input  logic                  RegDst,
    output logic [c_OPCODE_W-1:0] opCode,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic                  mem_we,
`ifdef DATAPATH_DBG_PORT_EN
    input  logic [4:0]            dbg_sel,
    output logic [DATA_W-1:0]     dbg_reg,
    output logic [DATA_W-1:0]     dbg_pc,
`endif
    input  logic [DATA_W-1:0]     mem_rdata
);

    logic [DATA_W-1:0] r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;

    logic [DATA_W-1:0]      w_rs_data, w_rt_data;
    logic [DATA_W-1:0]      w_sext_imm;
    logic [DATA_W-1:0]      w_alu_a, w_alu_b, w_alu_result;
    logic                   w_zero;
    logic [DATA_W-1:0]      w_pc_next;
    logic                   w_pc_en;
    logic [c_REG_IDX_W-1:0] w_wr_addr;
    logic [DATA_W-1:0]      w_wr_data;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    assign w_wr_addr = RegDst   ? r_ir[15:11] : r_ir[20:16];
    assign w_wr_data = MemtoReg ? r_mdr       : r_aluout;

    register_file #(
        .DATA_W      (DATA_W)
    ) u_register_file (
        .clk         (clk),
        .rst         (reset),
        .i_rd_addr_a (r_ir[25:21]),
        .i_rd_addr_b (r_ir[20:16]),
        .o_rd_data_a (w_rs_data),
        .o_rd_data_b (w_rt_data),
`ifdef DATAPATH_DBG_PORT_EN
        .i_dbg_addr  (dbg_sel),
        .o_dbg_data  (dbg_reg),
`endif
        .i_wr_en     (RegWrite),
        .i_wr_addr   (w_wr_addr),
        .i_wr_data   (w_wr_data)
    );

    // ------------------------------------------------------------------
    // ALU and operand muxes
    // ------------------------------------------------------------------
    assign w_sext_imm = sign_extend16(r_ir[15:0]);
    assign w_alu_a    = ALUSrcA ? r_a : r_pc;

    always_comb begin
        w_alu_b = r_b;
        case (ALUSrcB)
            c_SRCB_REG:     w_alu_b = r_b;
            c_SRCB_FOUR:    w_alu_b = DATA_W'(4);
            c_SRCB_IMM:     w_alu_b = w_sext_imm;
            c_SRCB_IMM_SH2: w_alu_b = w_sext_imm << 2;
            default:        w_alu_b = r_b;
        endcase
    end

    always_comb begin
        w_alu_result = '0;
        if (ALUOp) begin
            w_alu_result = w_alu_a + w_alu_b;
        end else begin
            case (r_ir[5:0])
                c_FUNCT_ADD: w_alu_result = w_alu_a + w_alu_b;
                c_FUNCT_SUB: w_alu_result = w_alu_a - w_alu_b;
                c_FUNCT_AND: w_alu_result = w_alu_a & w_alu_b;
                c_FUNCT_OR:  w_alu_result = w_alu_a | w_alu_b;
                c_FUNCT_SLT: w_alu_result = {{(DATA_W-1){1'b0}},
                                             ($signed(w_alu_a) < $signed(w_alu_b))};
                default:     w_alu_result = '0;
            endcase
        end
    end

    assign w_zero = (w_alu_result == '0);

    // ------------------------------------------------------------------
    // Next PC
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_next = r_pc;
        case (PCSource)
            c_PCSRC_ALU:    w_pc_next = w_alu_result;
            c_PCSRC_ALUOUT: w_pc_next = r_aluout;
            c_PCSRC_JUMP:   w_pc_next = {r_pc[31:28], r_ir[25:0], 2'b00};
            c_PCSRC_HOLD:   w_pc_next = r_pc;
            default:        w_pc_next = r_pc;
        endcase
    end

    assign w_pc_en = PCWrite | (PCWriteCond & w_zero);

    // ------------------------------------------------------------------
    // Architectural and pipeline-style registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else begin
            if (w_pc_en) begin
                r_pc <= w_pc_next;
            end
            if (IRWrite) begin
                r_ir <= mem_rdata;
            end
            // These latch every cycle; the control FSM decides when the
            // captured value is meaningful.
            r_mdr    <= mem_rdata;
            r_a      <= w_rs_data;
            r_b      <= w_rt_data;
            r_aluout <= w_alu_result;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign opCode    = r_ir[31:26];
    assign mem_addr  = IorD ? r_aluout : r_pc;
    assign mem_wdata = r_b;
    assign mem_we    = MemWrite & ~reset;

`ifdef DATAPATH_DBG_PORT_EN
    assign dbg_pc    = r_pc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_datapath.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_datapath
//  Purpose  : Self-checking bench for multicycle_datapath. Directed
//             instruction sequences with hand-computed results, then a
//             randomized control-word run compared against a behavioural
//             machine-state model. Connects the debug ports when
//             DATAPATH_DBG_PORT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_datapath;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        ALUOp, PCWriteCond, PCWrite, IorD, MemWrite, MemtoReg;
    logic        IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0]  ALUSrcB, PCSource;
    logic [5:0]  opCode;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
`ifdef DATAPATH_DBG_PORT_EN
    logic [4:0]  dbg_sel;
    logic [31:0] dbg_reg, dbg_pc;
`endif

    int n_checks = 0;
    int n_errors = 0;

    multicycle_datapath #(
        .DATA_W      (32),
        .RESET_PC    (c_RESET_PC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ALUOp       (ALUOp),
        .PCWriteCond (PCWriteCond),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .PCWrite     (PCWrite),
        .IorD        (IorD),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .opCode      (opCode),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_we      (mem_we),
`ifdef DATAPATH_DBG_PORT_EN
        .dbg_sel     (dbg_sel),
        .dbg_reg     (dbg_reg),
        .dbg_pc      (dbg_pc),
`endif
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference machine state
    // ------------------------------------------------------------------
    logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_aluout;
    logic [31:0] m_regs [32];

    function automatic logic [31:0] ref_alu(input logic force_add, input logic [5:0] funct,
                                            input logic [31:0] x, input logic [31:0] y);
        if (force_add) return x + y;
        case (funct)
            6'h20:   return x + y;
            6'h22:   return x - y;
            6'h24:   return x & y;
            6'h25:   return x | y;
            6'h2A:   return (int'(x) < int'(y)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_edge();
        int          imm;
        logic [31:0] op_a, op_b, res, new_a, new_b;
        int          dst;
        if (reset) begin
            m_pc = c_RESET_PC; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_aluout = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 0;
            return;
        end
        imm  = int'($signed(m_ir[15:0]));
        op_a = ALUSrcA ? m_a : m_pc;
        case (ALUSrcB)
            2'd0: op_b = m_b;
            2'd1: op_b = 32'd4;
            2'd2: op_b = imm;
            default: op_b = imm * 4;
        endcase
        res   = ref_alu(ALUOp, m_ir[5:0], op_a, op_b);
        new_a = m_regs[m_ir[25:21]];
        new_b = m_regs[m_ir[20:16]];
        if (RegWrite) begin
            dst = RegDst ? int'(m_ir[15:11]) : int'(m_ir[20:16]);
            if (dst != 0) m_regs[dst] = MemtoReg ? m_mdr : m_aluout;
        end
        if (PCWrite || (PCWriteCond && res == 0)) begin
            case (PCSource)
                2'd0: m_pc = res;
                2'd1: m_pc = m_aluout;
                2'd2: m_pc = (m_pc & 32'hF000_0000) | (32'(m_ir[25:0]) << 2);
                default: m_pc = m_pc;
            endcase
        end
        if (IRWrite) m_ir = mem_rdata;
        m_mdr    = mem_rdata;
        m_a      = new_a;
        m_b      = new_b;
        m_aluout = res;
    endtask

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic clear_ctrl();
        ALUOp = 0; PCWriteCond = 0; PCWrite = 0; IorD = 0; MemWrite = 0;
        MemtoReg = 0; IRWrite = 0; ALUSrcA = 0; RegWrite = 0; RegDst = 0;
        ALUSrcB = 2'b00; PCSource = 2'b00; mem_rdata = 32'h0;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] instr);
        clear_ctrl();
        mem_rdata = instr; IRWrite = 1;
        tick();
        clear_ctrl();
    endtask

    task automatic run_addi(input logic [31:0] instr);
        fetch(instr);
        tick();
        ALUSrcA = 1; ALUSrcB = 2'b10; ALUOp = 1;
        tick();
        clear_ctrl(); RegWrite = 1;
        tick();
        clear_ctrl();
    endtask

    task automatic run_rtype(input logic [31:0] instr);
        fetch(instr);
        tick();
        ALUSrcA = 1;
        tick();
        clear_ctrl(); RegWrite = 1; RegDst = 1;
        tick();
        clear_ctrl();
    endtask

    // Observe a register through B / mem_wdata.
    task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        logic [31:0] w;
        w = 32'h0;
        w[20:16] = idx;
        fetch(w);
        tick();
        check_value(tag, mem_wdata, exp);
    endtask

    task automatic do_branch(input logic [31:0] instr);
        fetch(instr);
        tick();
        ALUSrcA = 0; ALUSrcB = 2'b11; ALUOp = 1;
        tick();
        clear_ctrl(); ALUSrcA = 1; ALUSrcB = 2'b00; ALUOp = 0;
        PCSource = 2'b01; PCWriteCond = 1;
        tick();
        clear_ctrl();
    endtask

    logic [5:0] functs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        logic [31:0] w;
        clear_ctrl();
`ifdef DATAPATH_DBG_PORT_EN
        dbg_sel = 5'd0;
`endif
        // ---------------- reset overrides controls ----------------
        reset = 1; PCWrite = 1; IRWrite = 1; MemWrite = 1; ALUSrcB = 2'b01;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        check_value("reset_mem_we", {31'd0, mem_we}, 32'd0);
        tick();
        check_value("reset_opcode", {26'd0, opCode}, 32'd0);
        check_value("reset_pc", mem_addr, c_RESET_PC);
        check_value("reset_wdata", mem_wdata, 32'd0);
        IorD = 1; #1;
        check_value("reset_aluout", mem_addr, 32'd0);
        reset = 0;
        clear_ctrl();

        // ---------------- ADDI $8, $0, 5 ----------------
        fetch(32'h2008_0005);
        check_value("addi_opcode", {26'd0, opCode}, 32'h08);
        tick();
        ALUSrcA = 1; ALUSrcB = 2'b10; ALUOp = 1; IorD = 1;
        tick();
        check_value("addi_aluout", mem_addr, 32'd5);
        clear_ctrl(); RegWrite = 1;
        tick();
        clear_ctrl();
        check_reg("addi_r8", 5'd8, 32'd5);

        // ---------------- R-type ----------------
        run_addi(32'h2009_0007);
        check_reg("addi_r9", 5'd9, 32'd7);
        run_rtype(32'h0109_5022);                 // sub $10 = 5 - 7
        check_reg("sub_r10", 5'd10, 32'hFFFF_FFFE);
        run_rtype(32'h0148_582A);                 // slt $11 = (-2 < 5)
        check_reg("slt_neg_r11", 5'd11, 32'd1);
        run_rtype(32'h0109_502A);                 // slt $10 = (5 < 7)
        check_reg("slt_r10", 5'd10, 32'd1);
        run_rtype(32'h0109_6024);                 // and $12
        check_reg("and_r12", 5'd12, 32'd5);
        run_rtype(32'h0109_6825);                 // or $13
        check_reg("or_r13", 5'd13, 32'd7);
        run_rtype(32'h0109_6027);                 // unsupported funct
        check_reg("bad_funct_r12", 5'd12, 32'd0);
        run_rtype(32'h0109_0020);                 // add $0
        check_reg("write_r0", 5'd0, 32'd0);

        // ---------------- PC increment, hold, wrap ----------------
        ALUSrcB = 2'b01; ALUOp = 1; PCWrite = 1;
        tick();
        check_value("pc_inc", mem_addr, 32'd4);
        PCSource = 2'b11;
        tick();
        check_value("pc_hold", mem_addr, 32'd4);
        fetch(32'h2000_FFFC);
        tick();
        ALUSrcA = 1; ALUSrcB = 2'b10; ALUOp = 1;
        tick();
        clear_ctrl(); PCSource = 2'b01; PCWrite = 1;
        tick();
        check_value("pc_load_max", mem_addr, 32'hFFFF_FFFC);
        clear_ctrl(); ALUSrcB = 2'b01; ALUOp = 1; PCWrite = 1;
        tick();
        check_value("pc_wrap", mem_addr, 32'd0);
        clear_ctrl();

        // ---------------- branch ----------------
        run_addi(32'h200F_0003);
        run_addi(32'h2010_0003);
        run_addi(32'h2011_0004);
        fetch(32'h2000_0078);
        ALUSrcB = 2'b10; ALUOp = 1; PCWrite = 1;
        tick();
        check_value("pc_set_78", mem_addr, 32'h78);
        clear_ctrl();
        do_branch(32'h11F0_0022);                 // A == B
        check_value("branch_taken", mem_addr, 32'h100);
        do_branch(32'h11F1_0022);                 // A != B
        check_value("branch_not_taken", mem_addr, 32'h100);
        // ALUOut now holds 3-4; PCWrite must win over a false condition
        ALUSrcA = 1; PCSource = 2'b01; PCWriteCond = 1; PCWrite = 1;
        tick();
        check_value("pcwrite_dominates", mem_addr, 32'hFFFF_FFFF);
        clear_ctrl();

        // ---------------- jump ----------------
        fetch(32'h8C0E_0000);
        mem_rdata = 32'h4000_0004;
        tick();
        RegWrite = 1; MemtoReg = 1;
        tick();
        clear_ctrl();
        check_reg("lw_r14", 5'd14, 32'h4000_0004);
        fetch(32'h01C0_0000);
        tick();
        ALUSrcA = 1; ALUSrcB = 2'b10; ALUOp = 1; PCWrite = 1;
        tick();
        check_value("pc_set_jump_base", mem_addr, 32'h4000_0004);
        fetch(32'h0800_0010);
        PCSource = 2'b10; PCWrite = 1;
        tick();
        check_value("jump", mem_addr, 32'h4000_0040);
        clear_ctrl();

        // ---------------- randomized control words ----------------
        reset = 1;
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset       = ($urandom_range(0, 99) == 0);
            ALUOp       = 1'($urandom_range(0, 1));
            PCWriteCond = 1'($urandom_range(0, 1));
            PCWrite     = ($urandom_range(0, 3) == 0);
            IorD        = 1'($urandom_range(0, 1));
            MemWrite    = 1'($urandom_range(0, 1));
            MemtoReg    = 1'($urandom_range(0, 1));
            IRWrite     = ($urandom_range(0, 2) == 0);
            ALUSrcA     = 1'($urandom_range(0, 1));
            RegWrite    = 1'($urandom_range(0, 1));
            RegDst      = 1'($urandom_range(0, 1));
            ALUSrcB     = 2'($urandom_range(0, 3));
            PCSource    = 2'($urandom_range(0, 3));
            w = $urandom();
            if ($urandom_range(0, 1) == 1) begin
                w[31:26] = 6'h00;
                w[5:0]   = functs[$urandom_range(0, 4)];
            end
            mem_rdata = w;
`ifdef DATAPATH_DBG_PORT_EN
            dbg_sel = 5'($urandom_range(0, 31));
`endif
            tick();
            check_value("rnd_opcode", {26'd0, opCode}, {26'd0, m_ir[31:26]});
            check_value("rnd_mem_addr", mem_addr, IorD ? m_aluout : m_pc);
            check_value("rnd_mem_wdata", mem_wdata, m_b);
            check_value("rnd_mem_we", {31'd0, mem_we}, {31'd0, MemWrite & ~reset});
`ifdef DATAPATH_DBG_PORT_EN
            check_value("rnd_dbg_pc", dbg_pc, m_pc);
            check_value("rnd_dbg_reg", dbg_reg, m_regs[dbg_sel]);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
